iterative_restoring_divider_64_32: RTL
======================================

Name: iterative_restoring_divider_64_32

Overview:
Sequential unsigned divider and inverse companion to the 32-bit iterative Karatsuba multiplier. Divides a 2W-bit dividend, matching the multiplier's 64-bit product width, by a W-bit divisor. Produces a W-bit quotient and a W-bit remainder using restoring division at one quotient bit per cycle. Control is a small FSM with a start/done handshake and the codebase-standard enable freeze.

Parameters:
W, 32, divisor/quotient/remainder width; dividend is 2W bits.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
enable  input  1  global advance; 0 freezes all state and outputs
start  input  1  request; accepted only in IDLE with enable=1
dividend  input  2W  numerator, sampled on acceptance edge
divisor  input  W  denominator, sampled on acceptance edge
quotient  output  W  result quotient, registered
remainder  output  W  result remainder, registered
busy  output  1  high in ITER
done  output  1  high exactly while state==DONE, one enabled cycle
div_by_zero  output  1  registered flag for the current result
overflow  output  1  registered flag: quotient does not fit in W bits
check_err  output  1  present only with DIV_SELFCHECK_EN

Behaviour:
- Reset (async, any state):
  - state=IDLE; quotient, remainder, busy, done, div_by_zero, overflow all 0.
  - Internal R, Q, divisor copy and counter are cleared.
  - Reset mid-operation abandons the division; no done is produced.
- enable=0: no register changes in any state, including the counter and done. Outputs hold their values.
- States: IDLE, ITER, DONE. 2-bit encoding; illegal encodings go to IDLE.
- IDLE, start=1, enable=1 (acceptance edge):
  - Latch divisor into D.
  - Clear div_by_zero and overflow.
  - If D==0: div_by_zero=1, quotient=all-ones, remainder=dividend[W-1:0], go to DONE.
  - Else if dividend[2W-1:W] >= divisor: overflow=1, quotient=all-ones, remainder=0, go to DONE.
  - Else: R (W+1 bits) = {0, dividend[2W-1:W]}, Q = dividend[W-1:0], cnt=W-1, go to ITER.
- ITER, each enabled edge:
  - T = {R[W-1:0], Q[W-1]}.
  - If T >= {0,D}: R = T-D, qbit=1. Else: R = T, qbit=0.
  - Q = {Q[W-2:0], qbit}.
  - When cnt==0: load quotient=Q_next, remainder=R_next[W-1:0], go to DONE. Otherwise cnt decrements.
- DONE: done=1 for one enabled cycle, then IDLE. start is ignored in DONE.
- Latency:
  - Normal path: done rises W enabled edges after the acceptance edge (32 for W=32).
  - Zero-divisor and overflow paths: done rises 1 edge after acceptance.
- start is ignored while busy. dividend and divisor may change freely after acceptance.
- quotient, remainder and flags hold from DONE until the next acceptance edge. They are not cleared on return to IDLE.
- Invariant on the normal path: quotient*divisor + remainder == dividend, and remainder < divisor.

Optional Feature:
DIV_SELFCHECK_EN.
- Defined:
  - Adds output check_err and a 2W-bit copy of the accepted dividend.
  - In DONE on the normal path, a combinational W x W multiply computes quotient*D + remainder and compares it with the stored dividend.
  - check_err = 1 on mismatch, registered at DONE entry and held like the other flags.
  - check_err is 0 for the div_by_zero and overflow paths. Reset clears it.
- Undefined: the port, the dividend copy and the multiplier are absent. All other timing is identical.

Test Plan:
- dividend=100, divisor=7, one-cycle start -> busy for 32 cycles; done=1 on cycle 32 after acceptance; quotient=14, remainder=2, flags 0.
- dividend=64'hFFFF_FFFE_FFFF_FFFF, divisor=32'hFFFF_FFFF -> quotient=32'hFFFF_FFFF, remainder=32'hFFFF_FFFE, overflow=0.
- divisor=0, dividend=64'h1234_5678_9ABC_DEF0 -> done 1 cycle after acceptance; div_by_zero=1, quotient=32'hFFFF_FFFF, remainder=32'h9ABC_DEF0.
- dividend=64'h0000_0001_0000_0000, divisor=1 -> overflow=1, quotient=all-ones, remainder=0, done after 1 cycle.
- Mid-operation events:
  - start pulsed again during ITER with new operands -> ignored; the first result is intact.
  - enable=0 for 5 cycles in ITER -> done at cycle 37, same result.
  - rst pulsed mid-ITER, asynchronously -> all outputs 0 immediately, state IDLE, no done.
- With DIV_SELFCHECK_EN: random operands (dividend high word < divisor), 1000 divisions -> check_err stays 0.

Source files
------------

// File: rtl/iterative_restoring_divider_64_32.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per enabled cycle.
// Optional result self-check (port check_err) is built when DIV_SELFCHECK_EN is defined.
module iterative_restoring_divider_64_32 #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
`ifdef DIV_SELFCHECK_EN
  ,
  output logic           check_err
`endif
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  // Partial remainder is always below D, so its top (W+1-th) bit is never stored.
  logic [W-1:0]   r_q, r_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   quotient_q, quotient_d;
  logic [W-1:0]   remainder_q, remainder_d;
  logic           dbz_q, dbz_d;
  logic           ovf_q, ovf_d;

  logic [W:0]     t;
  logic           qbit;
  logic [W-1:0]   r_next;
  logic [W-1:0]   q_next;

`ifdef DIV_SELFCHECK_EN
  logic [2*W-1:0] dvd_q, dvd_d;
  logic           chk_q, chk_d;
  logic [2*W-1:0] recon;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    t      = {r_q, q_q[W-1]};
    qbit   = (t >= {1'b0, d_q});
    r_next = qbit ? W'(t - {1'b0, d_q}) : t[W-1:0];
    q_next = {q_q[W-2:0], qbit};

`ifdef DIV_SELFCHECK_EN
    dvd_d = dvd_q;
    chk_d = chk_q;
    recon = ({{W{1'b0}}, q_next} * {{W{1'b0}}, d_q}) + {{W{1'b0}}, r_next};
`endif

    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            d_d   = divisor;
            dbz_d = 1'b0;
            ovf_d = 1'b0;
`ifdef DIV_SELFCHECK_EN
            dvd_d = dividend;
            chk_d = 1'b0;
`endif
            if (divisor == '0) begin
              dbz_d       = 1'b1;
              quotient_d  = '1;
              remainder_d = dividend[W-1:0];
              state_d     = DONE;
            end else if (dividend[2*W-1:W] >= divisor) begin
              ovf_d       = 1'b1;
              quotient_d  = '1;
              remainder_d = '0;
              state_d     = DONE;
            end else begin
              r_d     = dividend[2*W-1:W];
              q_d     = dividend[W-1:0];
              cnt_d   = CW'(W - 1);
              state_d = ITER;
            end
          end
        end
        ITER: begin
          r_d = r_next;
          q_d = q_next;
          if (cnt_q == '0) begin
            quotient_d  = q_next;
            remainder_d = r_next;
            state_d     = DONE;
`ifdef DIV_SELFCHECK_EN
            chk_d = (recon != dvd_q);
`endif
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef DIV_SELFCHECK_EN
      dvd_q       <= '0;
      chk_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
`ifdef DIV_SELFCHECK_EN
      dvd_q       <= dvd_d;
      chk_q       <= chk_d;
`endif
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q == ITER);
  assign done        = (state_q == DONE);
`ifdef DIV_SELFCHECK_EN
  assign check_err   = chk_q;
`endif

endmodule
